// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store unit between a simple request/response
//   handshake and a word-wide synchronous data memory (read data returned the
//   cycle after MemRead). Byte and halfword stores are done as a
//   read-modify-write of the containing word.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword
//   and word accesses. When it is undefined, the low address bits below the
//   access size are ignored.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write              1 = store, 0 = load
//   req_size               00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_unsigned           load zero-extend (1) / sign-extend (0)
//   req_addr, req_wdata    byte address, right-justified store data
//   resp_valid             one-cycle completion pulse
//   resp_data, resp_error  load result (held until the next load), reject flag
//   MemRead, MemWrite      data memory strobes (never both high)
//   enderecoDeEntrada      data memory word index
//   writeData, readData    data memory write / read data
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] enderecoDeEntrada,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  localparam int unsigned AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_LDX,
    S_WR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_index;

  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_data;

  logic        w_accept;
  logic        w_misalign;
  logic        w_req_err;
  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  // Request decode
  always_comb begin
    w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    w_req_err = ({1'b0, req_addr} >= ADDR_LIMIT) || (req_size == 2'b11) || w_misalign;
  end

  assign w_accept = req_valid & req_ready;

  // Request latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_index    <= '0;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_wdata    <= req_wdata;
      r_index    <= 32'(req_addr[AW+1:2]);
    end
  end

  // Lane position: halfwords use only the upper lane bit, words start at lane 0
  always_comb begin
    case (r_size)
      2'b00:   w_shift = {r_lane, 3'b000};
      2'b01:   w_shift = {r_lane[1], 4'b0000};
      default: w_shift = 5'd0;
    endcase
  end

  assign w_shifted = readData >> w_shift;

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = readData;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane(s)
  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (readData & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_req_err)
          w_next = (req_write && (req_size == 2'b10)) ? S_WR : S_RD;
      end
      S_RD:    w_next = r_write ? S_WR : S_LDX;
      S_LDX:   w_next = S_IDLE;
      S_WR:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (r_state == S_IDLE);
    MemRead   = (r_state == S_RD);
    MemWrite  = (r_state == S_WR);
    writeData = '0;
    if (r_state == S_WR)
      writeData = (r_size == 2'b10) ? r_wdata : w_merged;
  end

  assign enderecoDeEntrada = r_index;

  // Response registers; a rejected request answers the cycle after acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= (w_accept && w_req_err) || (r_state == S_LDX) || (r_state == S_WR);
      r_resp_error <= w_accept && w_req_err;
      if (w_accept && w_req_err)
        r_resp_data <= '0;
      else if (r_state == S_LDX)
        r_resp_data <= w_load;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_error = r_resp_error;
  assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned AW        = $clog2(MEM_WORDS);

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] enderecoDeEntrada;
  logic [31:0] writeData;
  logic [31:0] readData = '0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .MemRead(MemRead), .MemWrite(MemWrite),
    .enderecoDeEntrada(enderecoDeEntrada), .writeData(writeData), .readData(readData)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Downstream synchronous RAM
  logic [31:0] ram [MEM_WORDS] = '{default: '0};
  logic [AW-1:0] w_idx;
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] last_wr_idx = '0;
  logic [31:0] last_wr_data = '0;
  assign w_idx = enderecoDeEntrada[AW-1:0];

  always @(posedge clock) begin
    if (MemWrite) begin
      ram[w_idx]   <= writeData;
      wr_count     <= wr_count + 1;
      last_wr_idx  <= enderecoDeEntrada;
      last_wr_data <= writeData;
    end
    if (MemRead) begin
      readData <= ram[w_idx];
      rd_count <= rd_count + 1;
    end
  end

  // Reference model: byte-addressed golden memory plus pending-response queue
  typedef struct {
    int        due;
    bit        err;
    bit        wr;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wd;
  } exp_t;

  bit [7:0] gm [4*MEM_WORDS] = '{default: '0};
  exp_t     q[$];
  int       cyc = 0;
  bit [31:0] exp_rd = '0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit model_err(input bit [1:0] sz, input bit [31:0] a);
    if (longint'(a) >= longint'(4 * MEM_WORDS)) return 1'b1;
    if (sz == 2'd3) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && a[0]) return 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit [31:0] model_load(input exp_t e);
    int n = nbytes(e.sz);
    int base = int'(e.addr) & ~(n - 1);
    bit [31:0] v = '0;
    bit [31:0] one = 32'd1;
    for (int i = 0; i < n; i++) v |= 32'(gm[base + i]) << (8 * i);
    if (!e.uns && n < 4 && v[8*n-1]) v |= ~((one << (8 * n)) - 1);
    return v;
  endfunction

  task automatic model_store(input exp_t e);
    int n = nbytes(e.sz);
    int base = int'(e.addr) & ~(n - 1);
    for (int i = 0; i < n; i++) gm[base + i] = e.wd[8*i +: 8];
  endtask

  always @(negedge clock) begin
    exp_t e;
    bit   exp_v;
    bit   exp_ready;
    if (!reset) begin
      q.delete();
      exp_rd = '0;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_error", resp_error, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_memrw", {MemRead, MemWrite}, 0);
      check("rst_index", enderecoDeEntrada, 0);
      check("rst_wdata", writeData, 0);
    end else begin
      exp_v     = (q.size() > 0) && (q[0].due == cyc);
      exp_ready = (q.size() == 0) || exp_v;
      check("req_ready", req_ready, exp_ready);
      check("resp_valid", resp_valid, exp_v);
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (exp_v) begin
          if (e.err)      exp_rd = '0;
          else if (!e.wr) exp_rd = model_load(e);
          else            model_store(e);
          check("resp_error", resp_error, e.err);
        end
      end
      check("resp_data", resp_data, exp_rd);
      check("mem_rw_excl", MemRead & MemWrite, 0);
      if (req_ready) check("idle_mem_quiet", {MemRead, MemWrite}, 0);
      if (req_valid && req_ready) begin
        e.err  = model_err(req_size, req_addr);
        e.wr   = req_write;
        e.sz   = req_size;
        e.uns  = req_unsigned;
        e.addr = req_addr;
        e.wd   = req_wdata;
        e.due  = cyc + 1 + (e.err ? 0 : (req_write && req_size == 2'd2) ? 1 : 2);
        q.push_back(e);
      end
    end
  end

  // Driver: called just after a rising edge; returns just after the accept edge
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bit got = 1'b0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no req_ready expected ready within 20 cycles");
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue_wait(input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] data, output logic err, output int lat);
    lat = -1; data = 'x; err = 1'bx;
    issue(w, sz, uns, a, wd);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (resp_valid) begin data = resp_data; err = resp_error; lat = i; break; end
    end
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        er;
    int          lat;
    int          wrc0, rdc0;
    logic [31:0] a, gw;
    logic [1:0]  sz;
    int          r;

    repeat (3) @(posedge clock);
    @(negedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", req_ready, 1);

    // store word then load word
    wrc0 = wr_count;
    issue_wait(1, 2'd2, 0, 32'h08, 32'hDEADBEEF, d, er, lat);
    check("sw08_lat", lat, 2);
    check("sw08_err", er, 0);
    check("sw08_wr_count", wr_count, wrc0 + 1);
    check("sw08_index", last_wr_idx, 2);
    check("sw08_wdata", last_wr_data, 32'hDEADBEEF);
    issue_wait(0, 2'd2, 0, 32'h08, 0, d, er, lat);
    check("lw08_data", d, 32'hDEADBEEF);
    check("lw08_lat", lat, 3);

    // byte store into a word, signed/unsigned byte loads
    issue_wait(1, 2'd2, 0, 32'h10, 32'h11223344, d, er, lat);
    issue_wait(1, 2'd0, 0, 32'h11, 32'h123456AA, d, er, lat);
    check("sb11_lat", lat, 3);
    issue_wait(0, 2'd2, 0, 32'h10, 0, d, er, lat);
    check("lw10_merged", d, 32'h1122AA44);
    issue_wait(0, 2'd0, 0, 32'h11, 0, d, er, lat);
    check("lb11_signed", d, 32'hFFFFFFAA);
    issue_wait(0, 2'd0, 1, 32'h11, 0, d, er, lat);
    check("lbu11", d, 32'h000000AA);

    // halfword store, signed halfword load, low half untouched
    issue_wait(1, 2'd2, 0, 32'h04, 32'h55667788, d, er, lat);
    issue_wait(1, 2'd1, 0, 32'h06, 32'hABCD8001, d, er, lat);
    issue_wait(0, 2'd1, 0, 32'h06, 0, d, er, lat);
    check("lh06_signed", d, 32'hFFFF8001);
    issue_wait(0, 2'd2, 0, 32'h04, 0, d, er, lat);
    check("lw04_low_kept", d, 32'h80017788);

    // out-of-range and reserved-size errors
    rdc0 = rd_count;
    issue_wait(0, 2'd2, 0, 32'h80, 0, d, er, lat);
    check("oob_err", er, 1);
    check("oob_lat", lat, 1);
    check("oob_data", d, 0);
    check("oob_no_read", rd_count, rdc0);
    issue_wait(0, 2'd3, 0, 32'h00, 0, d, er, lat);
    check("size11_err", er, 1);

    // misaligned word load
    issue_wait(0, 2'd2, 0, 32'h0A, 0, d, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw0a_err", er, 1);
    check("lw0a_lat", lat, 1);
`else
    check("lw0a_err", er, 0);
    check("lw0a_data", d, 32'hDEADBEEF);
`endif

    // reset during the write phase of a byte store
    issue(1, 2'd0, 0, 32'h12, 32'h00000055);
    r = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (MemWrite) begin r = 1; break; end
    end
    check("rmw_reached_wr", r, 1);
    wrc0 = wr_count;
    #2 reset = 1'b0;
    #1 check("rst_memwrite_drop", MemWrite, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    check("ready_after_midop_reset", req_ready, 1);
    check("midop_no_write", wr_count, wrc0);
    issue_wait(0, 2'd2, 0, 32'h10, 0, d, er, lat);
    check("lw10_unchanged", d, 32'h1122AA44);

    // randomized back-to-back traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 4 * MEM_WORDS - 4 + $urandom_range(0, 7);
      else             a = $urandom_range(0, 4 * MEM_WORDS - 1);
      r  = $urandom_range(0, 6);
      sz = (r == 6) ? 2'd3 : 2'(r % 3);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1;
      end
    end

    repeat (6) @(posedge clock);
    #1;
    check("queue_drained", q.size(), 0);
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      gw = {gm[4*i+3], gm[4*i+2], gm[4*i+1], gm[4*i]};
      check("mem_word", ram[i], gw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, the word depth of the downstream data memory (power of two, at least 2).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1 bit: on loads, 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_data, output, 32 bits: load result.
REQ-013 SHALL have port resp_error, output, 1 bit: the request was rejected without touching memory.
REQ-014 SHALL have ports MemRead (output, 1), MemWrite (output, 1), enderecoDeEntrada (output, 32: word index), writeData (output, 32) and readData (input, 32) toward the data memory.

Function
REQ-015 SHALL implement the states IDLE, RD, LDX and WR; req_ready = 1 only in IDLE; a request is accepted on a clock edge with req_valid & req_ready, and it latches all req_* fields.
REQ-016 SHALL, for an accepted request, form the word index addr[log2(MEM_WORDS)+1:2] zero-extended to 32 bits; the byte lane is addr[1:0], little-endian, lane n = bits 8n+7:8n.
REQ-017 SHALL flag an error when req_addr >= 4*MEM_WORDS or req_size = 11: no memory access, state stays IDLE, resp_valid = 1 and resp_error = 1 in the cycle after acceptance, resp_data = 0.
REQ-018 SHALL process a load as IDLE -> RD (MemRead = 1) -> LDX -> IDLE; at the LDX exit edge, resp_data is registered as the extracted and extended lane, so resp_valid occurs in the 3rd cycle after the accept edge.
REQ-019 SHALL process a word store as IDLE -> WR (MemWrite = 1, writeData = wdata) -> IDLE, with resp_valid in the cycle after WR.
REQ-020 SHALL process a byte or halfword store as a read-modify-write: IDLE -> RD -> WR, where writeData = readData with only the addressed lane(s) replaced by the low bits of wdata; resp_valid occurs in the cycle after WR.
REQ-021 SHALL never assert MemRead and MemWrite together, and SHALL keep both at 0 in IDLE.
REQ-022 SHALL drive resp_valid high for exactly one cycle per accepted request; resp_data holds until the next load response; resp_error = 0 on successful completions.
REQ-023 SHALL permit a new request to be accepted in the same cycle that resp_valid is high, giving back-to-back operation.
REQ-024 SHALL treat resp as always consumed, with no response back-pressure.

Reset
REQ-025 SHALL, while reset = 0, immediately and asynchronously force state IDLE, resp_valid = 0, resp_error = 0, resp_data = 0, MemRead = 0, MemWrite = 0, enderecoDeEntrada = 0 and writeData = 0.
REQ-026 SHALL discard an in-flight request when reset asserts mid-operation, with no response and no memory write; req_ready = 1 in the first cycle after reset is released.

Configuration
REQ-027 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat a halfword with addr[0] = 1 or a word with addr[1:0] != 0 as an error per REQ-017.
REQ-028 SHALL, without LSU_MISALIGN_TRAP_EN, never flag misalignment: a halfword ignores addr[0] and a word ignores addr[1:0].

Verification
REQ-029 SHALL cover: store word addr 0x08, data 0xDEADBEEF, then load word 0x08 -> MemWrite pulse at index 2, resp_data = 0xDEADBEEF, load resp 3 cycles after accept.
REQ-030 SHALL cover: word 0x11223344 at 0x10, store byte 0xAA to 0x11 -> memory word 0x1122AA44; a signed byte load from 0x11 -> 0xFFFFFFAA, and unsigned -> 0x000000AA.
REQ-031 SHALL cover: store halfword 0x8001 to 0x06, then signed halfword load from 0x06 -> 0xFFFF8001, and the low half of word index 1 is unchanged.
REQ-032 SHALL cover: load from 0x80 with MEM_WORDS = 32 -> resp_error = 1 one cycle after accept, MemRead never asserted.
REQ-033 SHALL cover: word load from 0x0A -> error with LSU_MISALIGN_TRAP_EN, and the contents of index 2 without it.
REQ-034 SHALL cover: reset = 0 asserted during WR of a byte store -> MemWrite drops immediately, memory unchanged, no resp_valid, and req_ready = 1 after release.
